// File: rtl/timing_param.sv
// Timebase and elapsed-time keeper: half-second/second strobes, an HH:MM:SS
// counter, and saturating second/minute accumulators with run/clear/preload.
module timing_param #(
  parameter int CLK_FREQ_HZ = 500000,
  parameter int HOURS_WRAP  = 100,
  parameter int ACCUM_W     = 13
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               clear,
  input  logic               load,
  input  logic [18:0]        load_time,
  output logic [18:0]        HMS_time,
  output logic [ACCUM_W-1:0] sec_accum,
  output logic [ACCUM_W-1:0] min_accum,
  output logic               half_sec_pulse,
  output logic               sec_pulse,
  output logic               load_err
);

  localparam int HALF = CLK_FREQ_HZ / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0]      PRESC_MAX = PW'(HALF - 1);
  localparam logic [6:0]         HR_MAX    = 7'(HOURS_WRAP - 1);
  localparam logic [ACCUM_W-1:0] ACC_MAX   = '1;

  logic [PW-1:0]      presc_q, presc_d;
  logic               phase_q, phase_d;
  logic [18:0]        hms_q, hms_d;
  logic [ACCUM_W-1:0] sec_acc_q, sec_acc_d;
  logic [ACCUM_W-1:0] min_acc_q, min_acc_d;
  logic               half_q, half_d;
  logic               spulse_q, spulse_d;
  logic               err_q, err_d;

  logic               tick;
  logic               load_ok;
  logic [5:0]         sec_n, min_n;
  logic [6:0]         hr_n;
  logic               min_roll;

  function automatic logic [ACCUM_W-1:0] sat_inc(input logic [ACCUM_W-1:0] v);
    return (v == ACC_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic time_valid(input logic [18:0] t);
    return (t[5:0] < 6'd60) && (t[11:6] < 6'd60) &&
           ({1'b0, t[18:12]} < 8'(HOURS_WRAP));
  endfunction

  assign tick    = run && (presc_q == PRESC_MAX);
  assign load_ok = load && time_valid(load_time);

  // Next HH:MM:SS value, used only on a second-generating tick.
  always_comb begin
    sec_n    = hms_q[5:0];
    min_n    = hms_q[11:6];
    hr_n     = hms_q[18:12];
    min_roll = 1'b0;
    if (hms_q[5:0] == 6'd59) begin
      sec_n    = 6'd0;
      min_roll = 1'b1;
      if (hms_q[11:6] == 6'd59) begin
        min_n = 6'd0;
        hr_n  = (hms_q[18:12] == HR_MAX) ? 7'd0 : hms_q[18:12] + 7'd1;
      end else begin
        min_n = hms_q[11:6] + 6'd1;
      end
    end else begin
      sec_n = hms_q[5:0] + 6'd1;
    end
  end

  always_comb begin
    presc_d   = presc_q;
    phase_d   = phase_q;
    hms_d     = hms_q;
    sec_acc_d = sec_acc_q;
    min_acc_d = min_acc_q;
    half_d    = 1'b0;
    spulse_d  = 1'b0;
    err_d     = 1'b0;
    if (clear) begin
      presc_d   = '0;
      phase_d   = 1'b0;
      hms_d     = '0;
      sec_acc_d = '0;
      min_acc_d = '0;
    end else if (load_ok) begin
      // A valid preload restarts the half-second phase and swallows any tick.
      hms_d   = load_time;
      presc_d = '0;
      phase_d = 1'b0;
    end else begin
      err_d = load;
      if (run) begin
        if (tick) begin
          presc_d = '0;
          phase_d = ~phase_q;
          half_d  = 1'b1;
          if (phase_q) begin
            spulse_d  = 1'b1;
            hms_d     = {hr_n, min_n, sec_n};
            sec_acc_d = sat_inc(sec_acc_q);
            if (min_roll) min_acc_d = sat_inc(min_acc_q);
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      phase_q   <= 1'b0;
      hms_q     <= '0;
      sec_acc_q <= '0;
      min_acc_q <= '0;
      half_q    <= 1'b0;
      spulse_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      hms_q     <= hms_d;
      sec_acc_q <= sec_acc_d;
      min_acc_q <= min_acc_d;
      half_q    <= half_d;
      spulse_q  <= spulse_d;
      err_q     <= err_d;
    end
  end

  assign HMS_time       = hms_q;
  assign sec_accum      = sec_acc_q;
  assign min_accum      = min_acc_q;
  assign half_sec_pulse = half_q;
  assign sec_pulse      = spulse_q;
  assign load_err       = err_q;

endmodule
